imem_fetch_sequencer: RTL

//  Sequences instruction fetch from the read-only instruction memory. Holds the PC, drives the

---
 rtl/imem_pkg.sv | 21 ++
 rtl/fetch_buffer.sv | 65 ++++++
 rtl/imem_fetch_sequencer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared types and widths for the instruction fetch path.
package imem_pkg;

  localparam int unsigned PC_W       = 64;
  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned ENTRY_W    = PC_W + INSTR_W;

  typedef enum logic [1:0] {
    WAIT,
    FULL,
    HALTED,
    FAULT
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of fetched {pc, instr} words; flush beats push/pop,
// and a push into a full buffer is accepted when a pop happens in the same cycle.
module fetch_buffer
  import imem_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  input  logic               flush,
  output logic [ENTRY_W-1:0] head,
  output logic               full,
  output logic               empty
);

  logic [ENTRY_W-1:0] slot_q [2];
  logic [ENTRY_W-1:0] slot_d [2];
  logic               rd_ptr_q, rd_ptr_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic [1:0]         count_q, count_d;
  logic               do_push, do_pop;

  assign full    = (count_q == 2'd2);
  assign empty   = (count_q == 2'd0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = slot_q[rd_ptr_q];

  always_comb begin
    slot_d   = slot_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        slot_d[wr_ptr_q] = push_data;
        wr_ptr_d         = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q   <= '{default: '0};
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      slot_q   <= slot_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/imem_fetch_sequencer.sv
// Instruction fetch sequencer: holds the PC, waits out memory latency, buffers words for decode.
// Optional IMEM_BOUNDS_CHECK_EN: stop fetching and raise sticky Fault at PC >= MEM_LIMIT.
module imem_fetch_sequencer
  import imem_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC    = 64'h0,
  parameter int unsigned     WAIT_CYCLES = 2,
  parameter logic [PC_W-1:0] MEM_LIMIT   = 64'h58
) (
  input  logic               CLK,
  input  logic               Reset,
  output logic [PC_W-1:0]    ImemAddress,
  input  logic [INSTR_W-1:0] ImemData,
  output logic [INSTR_W-1:0] InstrOut,
  output logic [PC_W-1:0]    PCOut,
  output logic               InstrValid,
  input  logic               InstrReady,
  input  logic               Redirect,
  input  logic [PC_W-1:0]    RedirectPC,
  input  logic               Halt,
  output logic               Fault
);

  localparam int unsigned     CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  fetch_state_t     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;

  logic             push, pop, flush;
  logic             buf_full, buf_empty;
  logic             capture_ok, at_cap, out_of_range;
  logic [PC_W-1:0]  redirect_pc;
  fetch_entry_t     push_entry, head_entry;
  logic [ENTRY_W-1:0] head_bits;

`ifdef IMEM_BOUNDS_CHECK_EN
  assign out_of_range = (pc_q >= MEM_LIMIT);
`else
  logic unused_limit;
  assign unused_limit = ^MEM_LIMIT;
  assign out_of_range = 1'b0;
`endif

  assign pop         = InstrValid && InstrReady;
  assign capture_ok  = !buf_full || pop;
  assign at_cap      = (cnt_q == CNT_LAST);
  assign redirect_pc = RedirectPC & ~PC_W'(WORD_BYTES - 1);
  assign push_entry  = '{pc: pc_q, instr: ImemData};
  assign head_entry  = fetch_entry_t'(head_bits);

  assign ImemAddress = pc_q;
  assign PCOut       = head_entry.pc;
  assign InstrOut    = head_entry.instr;
  assign InstrValid  = !buf_empty;
  assign Fault       = fault_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    push    = 1'b0;
    flush   = 1'b0;
    if (Redirect) begin
      flush   = 1'b1;
      pc_d    = redirect_pc;
      cnt_d   = '0;
      fault_d = 1'b0;
      state_d = Halt ? HALTED : WAIT;
    end else begin
      unique case (state_q)
        // Leaving HALTED counts as the first WAIT cycle, so the capture lands WAIT_CYCLES later.
        WAIT, HALTED: begin
          if (Halt) begin
            state_d = HALTED;
            cnt_d   = '0;
          end else if (at_cap) begin
            cnt_d = '0;
            if (out_of_range) begin
              fault_d = 1'b1;
              state_d = FAULT;
            end else if (capture_ok) begin
              push    = 1'b1;
              pc_d    = pc_q + PC_W'(WORD_BYTES);
              state_d = WAIT;
            end else begin
              cnt_d   = cnt_q;
              state_d = FULL;
            end
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = WAIT;
          end
        end
        FULL: begin
          if (Halt) begin
            state_d = HALTED;
            cnt_d   = '0;
          end else if (capture_ok) begin
            push    = 1'b1;
            pc_d    = pc_q + PC_W'(WORD_BYTES);
            cnt_d   = '0;
            state_d = WAIT;
          end
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: state_d = WAIT;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= WAIT;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  fetch_buffer u_buffer (
    .clk       (CLK),
    .rst       (Reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (flush),
    .head      (head_bits),
    .full      (buf_full),
    .empty     (buf_empty)
  );

endmodule
